// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide control block: widths, op encodings and
// the controller state enum.
package div_ctrl_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_RESP  = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    // DIV and REM are the signed flavours (low bit of the kind clear).
    function automatic logic kind_is_signed(input logic [1:0] kind);
        return ~kind[0];
    endfunction

    // REM and REMU return the remainder (high bit of the kind set).
    function automatic logic kind_is_rem(input logic [1:0] kind);
        return kind[1];
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle of the EX-stage offer, divider handshake and writeback signals
// around the divide controller. slave is the controller's view, master is
// the view of everything around it.
interface div_ctrl_if #(
    parameter int XLEN  = div_ctrl_pkg::XLEN,
    parameter int TAG_W = div_ctrl_pkg::TAG_W
);

    logic             flush;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_kind;
    logic             op_w;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] op_tag;

    logic             div_valid;
    logic             div_signed;
    logic             divw;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic             div_ready;
    logic             div_out_valid;
    logic [XLEN-1:0]  div_quot;
    logic [XLEN-1:0]  div_rema;

    logic             res_valid;
    logic             res_ready;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    modport slave (
        input  flush, op_valid, op_kind, op_w, src1, src2, op_tag,
        input  div_ready, div_out_valid, div_quot, div_rema, res_ready,
        output op_ready, div_valid, div_signed, divw, dividend, divisor,
        output res_valid, res_data, res_tag, busy
    );

    modport master (
        output flush, op_valid, op_kind, op_w, src1, src2, op_tag,
        output div_ready, div_out_valid, div_quot, div_rema, res_ready,
        input  op_ready, div_valid, div_signed, divw, dividend, divisor,
        input  res_valid, res_data, res_tag, busy
    );

endinterface

// File: rtl/div_special.sv
// Detects divide-by-zero and signed overflow on the offered operands and
// produces the architecturally fixed result for those cases, so they never
// have to visit the iterative divider.
module div_special #(
    parameter int XLEN = div_ctrl_pkg::XLEN
) (
    input  logic [1:0]      op_kind,
    input  logic            op_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            is_special,
    output logic [XLEN-1:0] result
);
    import div_ctrl_pkg::*;

    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] src1_eff;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rema;

    // Classify on 32 or XLEN bits and pick the fixed quotient/remainder.
    always_comb begin
        if (op_w) begin
            src1_eff = {{(XLEN-32){src1[31]}}, src1[31:0]};
            div_zero = (src2[31:0] == 32'd0);
            overflow = kind_is_signed(op_kind) && (src1[31:0] == 32'h8000_0000)
                       && (&src2[31:0]);
        end else begin
            src1_eff = src1;
            div_zero = (src2 == '0);
            overflow = kind_is_signed(op_kind)
                       && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
        end
        is_special = div_zero | overflow;
        if (div_zero) begin
            quot = '1;
            rema = src1_eff;
        end else begin
            quot = src1_eff;
            rema = '0;
        end
        result = kind_is_rem(op_kind) ? rema : quot;
    end

endmodule

// File: rtl/div_ctrl.sv
// Divide controller: accepts a divide op from EX, short-circuits the special
// cases, otherwise runs the shared iterative divider and holds the result
// until writeback takes it. A flushed divider run is drained before reuse.
module div_ctrl #(
    parameter int XLEN  = div_ctrl_pkg::XLEN,
    parameter int TAG_W = div_ctrl_pkg::TAG_W
) (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.slave  bus
);
    import div_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic             w_q, w_d;
    logic [XLEN-1:0]  src1_q, src1_d;
    logic [XLEN-1:0]  src2_q, src2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             div_valid_q, div_valid_d;
    logic             res_valid_q, res_valid_d;
    logic [XLEN-1:0]  res_data_q, res_data_d;

    logic             accept;
    logic             special;
    logic [XLEN-1:0]  special_res;
    logic [XLEN-1:0]  div_pick;
    logic [XLEN-1:0]  div_final;

    div_special #(.XLEN(XLEN)) u_special (
        .op_kind    (bus.op_kind),
        .op_w       (bus.op_w),
        .src1       (bus.src1),
        .src2       (bus.src2),
        .is_special (special),
        .result     (special_res)
    );

    assign bus.op_ready   = (state_q == S_IDLE) && bus.div_ready;
    assign bus.div_valid  = div_valid_q;
    assign bus.div_signed = kind_is_signed(kind_q);
    assign bus.divw       = w_q;
    assign bus.dividend   = src1_q;
    assign bus.divisor    = src2_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_tag    = tag_q;
    assign bus.busy       = (state_q != S_IDLE);

    // Next-state and next-register values; flush outranks completion/consume.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        w_d         = w_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        tag_d       = tag_q;
        div_valid_d = div_valid_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        accept    = bus.op_valid && bus.op_ready && !bus.flush;
        div_pick  = kind_is_rem(kind_q) ? bus.div_rema : bus.div_quot;
        div_final = w_q ? {{(XLEN-32){div_pick[31]}}, div_pick[31:0]} : div_pick;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    kind_d = bus.op_kind;
                    w_d    = bus.op_w;
                    src1_d = bus.src1;
                    src2_d = bus.src2;
                    tag_d  = bus.op_tag;
                    if (special) begin
                        res_data_d  = special_res;
                        res_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        div_valid_d = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    // A result arriving with the flush is already spent, so
                    // there is nothing left to drain.
                    div_valid_d = 1'b0;
                    state_d     = bus.div_out_valid ? S_IDLE : S_DRAIN;
                end else if (bus.div_out_valid) begin
                    res_data_d  = div_final;
                    div_valid_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.flush || bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= '0;
            w_q         <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            tag_q       <= '0;
            div_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            w_q         <= w_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            tag_q       <= tag_d;
            div_valid_q <= div_valid_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural divider with adjustable
// latency, directed scenarios for the documented corner cases, then random
// ops compared against a RISC-V divide/remainder reference.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int XL = 64;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_ctrl_if #(.XLEN(XL), .TAG_W(TW)) bus ();

    div_ctrl #(.XLEN(XL), .TAG_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int div_lat    = 130;
    int div_starts = 0;

    logic        dv_active = 1'b0;
    logic        dv_prev_out = 1'b0;
    int          dv_count = 0;
    logic [63:0] dv_a, dv_b;
    logic        dv_s, dv_w;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension divide/remainder, including the W forms.
    function automatic void rv_divrem(input logic sgn, input logic w, input logic [63:0] a,
                                      input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
            else if (sgn) begin q32 = 32'(int'(a32) / int'(b32)); r32 = 32'(int'(a32) % int'(b32)); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin q = '1; r = a; end
            else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
            else if (sgn) begin q = 64'(longint'(a) / longint'(b)); r = 64'(longint'(a) % longint'(b)); end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] kind, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        rv_divrem(!kind[0], w, a, b, q, r);
        return kind[1] ? r : q;
    endfunction

    function automatic bit ref_special(input logic [1:0] kind, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        if (w)
            return (b[31:0] == 0) || (!kind[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (!kind[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Behavioural iterative divider: fixed latency per run, garbage upper
    // half on W results, and it keeps running even if its request drops.
    always @(negedge clk) begin
        logic [63:0] q, r;
        if (reset) begin
            dv_active         = 1'b0;
            dv_prev_out       = 1'b0;
            bus.div_out_valid = 1'b0;
            bus.div_quot      = '0;
            bus.div_rema      = '0;
            bus.div_ready     = 1'b1;
        end else begin
            if (dv_prev_out)
                checkOutput("div_valid_after_out", bus.div_valid, 1'b0);
            bus.div_out_valid = 1'b0;
            if (dv_active) begin
                if (bus.div_valid)
                    checkOutput("div_in_stable",
                                (bus.dividend == dv_a && bus.divisor == dv_b &&
                                 bus.div_signed == dv_s && bus.divw == dv_w), 1'b1);
                dv_count--;
                if (dv_count <= 0) begin
                    rv_divrem(dv_s, dv_w, dv_a, dv_b, q, r);
                    if (dv_w) begin
                        q[63:32] = $urandom;
                        r[63:32] = $urandom;
                    end
                    bus.div_quot      = q;
                    bus.div_rema      = r;
                    bus.div_out_valid = 1'b1;
                    dv_active         = 1'b0;
                end
            end else if (bus.div_valid) begin
                dv_a      = bus.dividend;
                dv_b      = bus.divisor;
                dv_s      = bus.div_signed;
                dv_w      = bus.divw;
                dv_count  = div_lat;
                dv_active = 1'b1;
                div_starts++;
            end
            dv_prev_out   = bus.div_out_valid;
            bus.div_ready = !dv_active && !bus.div_out_valid;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] tag);
        int n = 0;
        bus.op_valid = 1'b1;
        bus.op_kind  = kind;
        bus.op_w     = w;
        bus.src1     = a;
        bus.src2     = b;
        bus.op_tag   = tag;
        while (!bus.op_ready && n < 1000) begin
            step();
            n++;
        end
        checkOutput("accept_wait", bus.op_ready, 1'b1);
        step();
        bus.op_valid = 1'b0;
    endtask

    // Full op: acceptance, divider-request or immediate-result check, result,
    // hold with res_ready low, then consume.
    task automatic runOp(input logic [1:0] kind, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input int hold);
        int          n = 0;
        int          starts0 = div_starts;
        bit          sp = ref_special(kind, w, a, b);
        logic [63:0] exp = ref_result(kind, w, a, b);
        applyStimulus(kind, w, a, b, tag);
        if (sp) begin
            checkOutput("special_resp_next", bus.res_valid, 1'b1);
        end else begin
            checkOutput("req_fields", {bus.div_valid, bus.div_signed, bus.divw, bus.busy},
                        {1'b1, !kind[0], w, 1'b1});
            checkOutput("req_dividend", bus.dividend, a);
            checkOutput("req_divisor", bus.divisor, b);
        end
        while (!bus.res_valid && n < 400) begin
            step();
            n++;
        end
        checkOutput("res_valid_wait", bus.res_valid, 1'b1);
        checkOutput("res_data", bus.res_data, exp);
        checkOutput("res_tag", bus.res_tag, tag);
        checkOutput("div_valid_in_resp", bus.div_valid, 1'b0);
        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput("res_hold_valid", bus.res_valid, 1'b1);
            checkOutput("res_hold_data", bus.res_data, exp);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        checkOutput("idle_after_resp", {bus.res_valid, bus.busy}, 2'b00);
        checkOutput("div_start_count", div_starts - starts0, sp ? 0 : 1);
    endtask

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return {$urandom, 32'h8000_0000};
            5: return 64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  n;
        bit  saw_res, saw_ready;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_kind   = 2'b00;
        bus.op_w      = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.op_tag    = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_flags", {bus.res_valid, bus.div_valid, bus.busy, bus.op_ready}, 4'b0001);
        checkOutput("rst_res_data", bus.res_data, 64'd0);
        checkOutput("rst_res_tag", bus.res_tag, 64'd0);
        checkOutput("rst_operands", bus.dividend | bus.divisor, 64'd0);

        // DIV -7 / 2 with the result held for three cycles
        runOp(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 3);
        checkOutput("div_neg7_by_2", ref_result(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2),
                    64'hFFFF_FFFF_FFFF_FFFD);

        // Special cases: divide by zero, W and 64-bit signed overflow
        runOp(OP_REMU, 1'b0, 64'h1234, 64'd0, 5'd4, 1);
        runOp(OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 0);
        runOp(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 0);
        runOp(OP_DIVU, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd7, 0);

        // DIVUW still sign-extends bit 31 of the 32-bit quotient
        div_lat = 20;
        runOp(OP_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 5'd8, 0);

        // Flush 20 cycles into a run: drain until the divider finishes
        div_lat = 130;
        applyStimulus(OP_DIV, 1'b0, 64'd100, 64'd7, 5'd9);
        repeat (20) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checkOutput("flush_wait_state", {bus.div_valid, bus.busy, bus.res_valid}, 3'b010);
        n = 0; saw_res = 1'b0; saw_ready = 1'b0;
        while (bus.busy && n < 400) begin
            if (bus.res_valid) saw_res = 1'b1;
            if (bus.op_ready) saw_ready = 1'b1;
            step();
            n++;
        end
        checkOutput("drain_done", bus.busy, 1'b0);
        checkOutput("drain_no_result", saw_res, 1'b0);
        checkOutput("drain_no_ready", saw_ready, 1'b0);
        checkOutput("drain_length", (n > 90), 1'b1);
        runOp(OP_REM, 1'b0, 64'd100, 64'd7, 5'd10, 1);

        // Reset in the middle of a divider run
        applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3, 5'd11);
        repeat (10) step();
        reset = 1'b1;
        step();
        checkOutput("rst_in_wait", {bus.div_valid, bus.res_valid, bus.busy}, 3'b000);
        reset = 1'b0;
        runOp(OP_DIV, 1'b0, 64'd1000, 64'd3, 5'd12, 0);

        // Flush while a result is waiting for writeback
        applyStimulus(OP_REMU, 1'b0, 64'h55, 64'd0, 5'd13);
        checkOutput("resp_before_flush", bus.res_valid, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checkOutput("flush_in_resp", {bus.res_valid, bus.busy}, 2'b00);

        // Flush together with an offer in IDLE blocks acceptance
        bus.op_valid = 1'b1;
        bus.op_kind  = OP_DIV;
        bus.op_w     = 1'b0;
        bus.src1     = 64'd9;
        bus.src2     = 64'd0;
        bus.flush    = 1'b1;
        step();
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        checkOutput("flush_in_idle", {bus.res_valid, bus.busy, bus.div_valid}, 3'b000);

        // Random ops against the reference
        for (int i = 0; i < 40; i++) begin
            div_lat = $urandom_range(2, 40);
            runOp(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                  5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: XLEN, 64, operand/result width.
REQ-002 Parameter: TAG_W, 5, destination register tag width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 flush  in  1  pipeline kill; cancels the in-flight or offered op.
REQ-006 op_valid  in  1  EX stage offers a divide op.
REQ-007 op_ready  out  1  op accepted when op_valid and op_ready are both high.
REQ-008 op_kind  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 op_w  in  1  RV64 W variant; 32-bit operation.
REQ-010 src1 / src2  in  XLEN  dividend / divisor.
REQ-011 op_tag  in  TAG_W  destination tag.
REQ-012 div_valid, div_signed, divw  out  1  request to the iterative divider.
REQ-013 dividend, divisor  out  XLEN  divider operands.
REQ-014 div_ready, div_out_valid  in  1  divider idle / result-valid.
REQ-015 div_quot, div_rema  in  XLEN  divider results.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  writeback consumes the result.
REQ-018 res_data  out  XLEN  final result.
REQ-019 res_tag  out  TAG_W  tag of the result.
REQ-020 busy  out  1  high in any state other than IDLE; drives the EX stall.

Function
REQ-021 The block SHALL implement states IDLE, WAIT, RESP and DRAIN.
REQ-022 op_ready SHALL equal (state==IDLE) and div_ready.
REQ-023 On acceptance the block SHALL register op_kind, op_w, src1, src2 and op_tag.
REQ-024 A special case SHALL be divisor==0, or signed overflow (dividend at its minimum value and divisor all ones), evaluated on 32 bits when op_w is set.
REQ-025 An accepted special case SHALL go IDLE->RESP in one cycle and SHALL leave div_valid low.
  - Divide by zero: quotient all ones; remainder = dividend.
  - Overflow: quotient = dividend; remainder 0.
REQ-026 A non-special op SHALL go IDLE->WAIT with div_valid, div_signed (op_kind[0]==0), divw (op_w) and operands registered high/stable.
REQ-027 In WAIT, div_valid and all divider inputs SHALL stay constant until div_out_valid is sampled high, because the divider derives result signs combinationally throughout.
REQ-028 On div_out_valid in WAIT, the block SHALL do all of the following in the same cycle:
  - capture div_quot (DIV/DIVU) or div_rema (REM/REMU);
  - clear div_valid;
  - go to RESP.
REQ-029 W results SHALL be the low 32 bits sign-extended from bit 31, including the unsigned W variants.
REQ-030 In RESP, res_valid SHALL be held with res_data and res_tag stable until res_ready, then the block SHALL return to IDLE.
REQ-031 flush in WAIT SHALL clear div_valid and go to DRAIN.
REQ-032 DRAIN SHALL wait for div_out_valid, discard the result, then go to IDLE.
REQ-033 flush in RESP SHALL drop res_valid and go to IDLE.
REQ-034 flush in IDLE SHALL block acceptance in that cycle.
REQ-035 flush SHALL have priority over div_out_valid and res_ready in the same cycle.
REQ-036 div_valid SHALL be low in the cycle after div_out_valid, so the divider cannot restart.
REQ-037 No fixed latency SHALL be assumed; the current divider produces its result 130 cycles after div_valid.

Reset
REQ-038 On reset the block SHALL set state IDLE, and set div_valid, res_valid, res_data, res_tag and all registered operands to 0.
REQ-039 Reset mid-WAIT SHALL abandon the op with no drain; the divider shares this reset.

Structure
REQ-040 A shared package SHALL hold the op_kind encodings, the state enum and XLEN.
REQ-041 Special-case detection and its fixed result SHALL be one combinational sub-module, div_special.
REQ-042 The RTL SHALL be 120-400 lines.

Verification
REQ-043 DIV src1=0xFFFFFFFFFFFFFFF9, src2=2 -> res_data=0xFFFFFFFFFFFFFFFD; res_valid held 3 cycles with res_ready low.
REQ-044 REMU src1=0x1234, src2=0 -> res_data=0x1234 in RESP the cycle after acceptance; div_valid never asserted.
REQ-045 DIVW src1=0x80000000, src2=0xFFFFFFFF -> 0xFFFFFFFF80000000; DIV src1=0x8000000000000000, src2=all ones -> 0x8000000000000000.
REQ-046 DIVUW src1=0xFFFFFFFE, src2=1 -> 0xFFFFFFFFFFFFFFFE.
REQ-047 flush 20 cycles into DIV 100/7 -> no res_valid; op_ready low until div_out_valid; next REM 100/7 returns 2.
REQ-048 Reset asserted in WAIT -> next cycle div_valid=0, res_valid=0, busy=0; a new op then completes correctly.
